// File: rtl/hdc_similarity_classifier.sv
// -----------------------------------------------------------------------------
// hdc_similarity_classifier
//
// Streams a bipolar message hypervector and compares it against stored ham and
// spam class vectors. The dot products and squared class norms are accumulated
// in a single pass. The cosine decision is then made exactly by integer
// cross-multiplication, with no square root and no division.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-low reset
//   cls_we/sel/addr/  class-memory write port (sel 0 = ham, 1 = spam);
//   cls_wdata         honoured only while idle
//   in_valid/ready/   message element stream (01 = +1, 11 = -1, 00/10 = 0);
//   in_data/in_last   in_last marks the final element of a frame
//   out_valid         one-cycle pulse; result and len_err are valid with it
//   result            0 = ham, 1 = spam, 2'b11 = tie or undecidable
//   len_err           frame length differed from DIM
//   dot_ham/dot_spam  signed dot products of the last completed frame
// -----------------------------------------------------------------------------
module hdc_similarity_classifier #(
    parameter int DIM          = 10000,
    parameter int BITS_PER_INT = 16,
    parameter int ACC_W        = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cls_we,
    input  logic                     cls_sel,
    input  logic [$clog2(DIM)-1:0]   cls_addr,
    input  logic [BITS_PER_INT-1:0]  cls_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic [1:0]               result,
    output logic                     len_err,
    output logic [ACC_W-1:0]         dot_ham,
    output logic [ACC_W-1:0]         dot_spam
);
    localparam int AW = $clog2(DIM);
    localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, SQUARE, CROSS, DECIDE} state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic signed [1:0]          m_q, m_d;
    logic                       pend_q, pend_d;
    logic signed [ACC_W-1:0]    dh_q, dh_d, ds_q, ds_d, sh_q, sh_d, ss_q, ss_d;
    logic                       len_flag_q, len_flag_d;
    logic [2*ACC_W-1:0]         dh2_q, dh2_d, ds2_q, ds2_d;
    logic signed [1:0]          sgn_h_q, sgn_h_d, sgn_s_q, sgn_s_d;
    logic [3*ACC_W-1:0]         l_q, l_d, r_q, r_d;
    logic                       out_valid_q, out_valid_d;
    logic [1:0]                 result_q, result_d;
    logic                       len_err_q, len_err_d;
    logic [ACC_W-1:0]           dot_ham_q, dot_ham_d, dot_spam_q, dot_spam_d;

    logic                       accept, at_last, rd_en, wr_en;
    logic [AW-1:0]              idx, rd_addr;
    logic signed [ACC_W-1:0]    m_ext, h_ext, s_ext;
    logic [ACC_W-1:0]           abs_dh, abs_ds;

    logic signed [BITS_PER_INT-1:0] ham_mem  [0:DIM-1];
    logic signed [BITS_PER_INT-1:0] spam_mem [0:DIM-1];
    logic signed [BITS_PER_INT-1:0] ham_rd_q, spam_rd_q;

    assign wr_en = cls_we && (state_q == IDLE);

    // Class RAMs: no reset so contents survive reset; the read register keeps
    // the old word when a write hits the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !cls_sel) ham_mem[cls_addr]  <= cls_wdata;
        if (wr_en &&  cls_sel) spam_mem[cls_addr] <= cls_wdata;
        if (rd_en) begin
            ham_rd_q  <= ham_mem[rd_addr];
            spam_rd_q <= spam_mem[rd_addr];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        dh_d        = dh_q;
        ds_d        = ds_q;
        sh_d        = sh_q;
        ss_d        = ss_q;
        len_flag_d  = len_flag_q;
        dh2_d       = dh2_q;
        ds2_d       = ds2_q;
        sgn_h_d     = sgn_h_q;
        sgn_s_d     = sgn_s_q;
        l_d         = l_q;
        r_d         = r_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        len_err_d   = len_err_q;
        dot_ham_d   = dot_ham_q;
        dot_spam_d  = dot_spam_q;

        in_ready = (state_q == IDLE) || (state_q == ACCUM);
        accept   = in_valid && in_ready;
        idx      = (state_q == IDLE) ? '0 : cnt_q;
        at_last  = (idx == LAST_IDX);
        rd_en    = accept;
        rd_addr  = idx;
        pend_d   = accept;

        m_ext  = ACC_W'(m_q);
        h_ext  = ACC_W'(ham_rd_q);
        s_ext  = ACC_W'(spam_rd_q);
        abs_dh = dh_q[ACC_W-1] ? -dh_q : dh_q;
        abs_ds = ds_q[ACC_W-1] ? -ds_q : ds_q;

        // RAM data lags the accepted beat by one cycle, so the element
        // registered last cycle is folded in whenever a read is pending.
        if (pend_q) begin
            dh_d = dh_q + m_ext * h_ext;
            ds_d = ds_q + m_ext * s_ext;
            sh_d = sh_q + h_ext * h_ext;
            ss_d = ss_q + s_ext * s_ext;
        end

        if (accept) begin
            case (in_data)
                2'b01:   m_d = 2'sb01;
                2'b11:   m_d = 2'sb11;
                default: m_d = 2'sb00;
            endcase
            cnt_d = idx + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dh_d = '0;
                    ds_d = '0;
                    sh_d = '0;
                    ss_d = '0;
                    if (in_last || at_last) begin
                        state_d    = DRAIN;
                        len_flag_d = in_last ^ at_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept && (in_last || at_last)) begin
                    state_d    = DRAIN;
                    len_flag_d = in_last ^ at_last;
                end
            end
            DRAIN: begin
                state_d    = SQUARE;
                dot_ham_d  = dh_d;
                dot_spam_d = ds_d;
            end
            SQUARE: begin
                state_d = CROSS;
                dh2_d   = {{ACC_W{1'b0}}, abs_dh} * {{ACC_W{1'b0}}, abs_dh};
                ds2_d   = {{ACC_W{1'b0}}, abs_ds} * {{ACC_W{1'b0}}, abs_ds};
                sgn_h_d = (sh_q == '0 || dh_q == '0) ? 2'sb00 :
                          (dh_q[ACC_W-1] ? 2'sb11 : 2'sb01);
                sgn_s_d = (ss_q == '0 || ds_q == '0) ? 2'sb00 :
                          (ds_q[ACC_W-1] ? 2'sb11 : 2'sb01);
            end
            CROSS: begin
                state_d = DECIDE;
                l_d = {{ACC_W{1'b0}}, dh2_q} * {{2*ACC_W{1'b0}}, ss_q};
                r_d = {{ACC_W{1'b0}}, ds2_q} * {{2*ACC_W{1'b0}}, sh_q};
            end
            DECIDE: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                len_err_d   = len_flag_q;
                // Compare cos_h against cos_s: opposite signs settle it
                // directly; equal signs compare dh^2*ss against ds^2*sh, with
                // the ordering flipped when both are negative.
                if (sgn_h_q != sgn_s_q)      result_d = (sgn_h_q > sgn_s_q) ? 2'b00 : 2'b01;
                else if (sgn_h_q == 2'sb00)  result_d = 2'b11;
                else if (l_q == r_q)         result_d = 2'b11;
                else if (sgn_h_q == 2'sb01)  result_d = (l_q > r_q) ? 2'b00 : 2'b01;
                else                         result_d = (l_q < r_q) ? 2'b00 : 2'b01;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            pend_q      <= 1'b0;
            dh_q        <= '0;
            ds_q        <= '0;
            sh_q        <= '0;
            ss_q        <= '0;
            len_flag_q  <= 1'b0;
            dh2_q       <= '0;
            ds2_q       <= '0;
            sgn_h_q     <= '0;
            sgn_s_q     <= '0;
            l_q         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            len_err_q   <= 1'b0;
            dot_ham_q   <= '0;
            dot_spam_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            pend_q      <= pend_d;
            dh_q        <= dh_d;
            ds_q        <= ds_d;
            sh_q        <= sh_d;
            ss_q        <= ss_d;
            len_flag_q  <= len_flag_d;
            dh2_q       <= dh2_d;
            ds2_q       <= ds2_d;
            sgn_h_q     <= sgn_h_d;
            sgn_s_q     <= sgn_s_d;
            l_q         <= l_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            len_err_q   <= len_err_d;
            dot_ham_q   <= dot_ham_d;
            dot_spam_q  <= dot_spam_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign len_err   = len_err_q;
    assign dot_ham   = dot_ham_q;
    assign dot_spam  = dot_spam_q;

endmodule

// File: tb/tb_hdc_similarity_classifier.sv
// -----------------------------------------------------------------------------
// Testbench for hdc_similarity_classifier (DIM = 8). Each frame's expected
// decision, flags, dot products and output cycle are computed from a small
// reference model and pushed to a scoreboard; a monitor pops and compares
// whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_hdc_similarity_classifier;
    localparam int DIM   = 8;
    localparam int B     = 16;
    localparam int ACC_W = 48;

    logic              clk = 1'b0;
    logic              reset;
    logic              cls_we;
    logic              cls_sel;
    logic [2:0]        cls_addr;
    logic [B-1:0]      cls_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_data;
    logic              in_last;
    logic              out_valid;
    logic [1:0]        result;
    logic              len_err;
    logic [ACC_W-1:0]  dot_ham;
    logic [ACC_W-1:0]  dot_spam;

    hdc_similarity_classifier #(.DIM(DIM), .BITS_PER_INT(B), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .cls_we(cls_we), .cls_sel(cls_sel), .cls_addr(cls_addr), .cls_wdata(cls_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .result(result), .len_err(len_err),
        .dot_ham(dot_ham), .dot_spam(dot_spam)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] res;
        logic       lerr;
        longint     dh;
        longint     ds;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ham_m[DIM];
    int   spam_m[DIM];
    int   msg[DIM];
    int   first_acc;
    int   end_acc;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            check("out_valid_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result",   64'(result), 64'(e.res));
                check("len_err",  64'(len_err), 64'(e.lerr));
                check("dot_ham",  64'($signed(dot_ham)), e.dh);
                check("dot_spam", 64'($signed(dot_spam)), e.ds);
                check("latency",  64'(cyc), 64'(e.due));
            end
        end
    end

    function automatic logic [1:0] enc(input int m);
        if (m == 1)  return 2'b01;
        if (m == -1) return 2'b11;
        return 2'b00;
    endfunction

    task automatic load_mem(input bit sel);
        for (int i = 0; i < DIM; i++) begin
            cls_we    = 1'b1;
            cls_sel   = sel;
            cls_addr  = 3'(i);
            cls_wdata = sel ? B'(spam_m[i]) : B'(ham_m[i]);
            @(posedge clk); #1;
        end
        cls_we = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    // Drives n beats of msg; in_last on beat n-1 when give_last. gap_at
    // inserts an in_valid=0 stall before that beat; we_at3 pulses cls_we
    // (ham[0] <= -5) together with beat 3.
    task automatic run_frame(input int n, input bit give_last, input bit hold_valid,
                             input int gap_at, input bit we_at3);
        longint dh = 0, ds = 0, sh = 0, ss = 0, a, b, lhs, rhs;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            dh += msg[i] * ham_m[i];
            ds += msg[i] * spam_m[i];
            sh += ham_m[i] * ham_m[i];
            ss += spam_m[i] * spam_m[i];
        end
        // cos_h > cos_s  <=>  dh|dh|/sh > ds|ds|/ss ; zero-norm classes score 0
        a   = (sh == 0) ? 0 : dh * (dh < 0 ? -dh : dh);
        b   = (ss == 0) ? 0 : ds * (ds < 0 ? -ds : ds);
        lhs = a * (ss == 0 ? 1 : ss);
        rhs = b * (sh == 0 ? 1 : sh);
        e.res  = (lhs > rhs) ? 2'b00 : (lhs < rhs) ? 2'b01 : 2'b11;
        e.lerr = !(n == DIM && give_last);
        e.dh   = dh;
        e.ds   = ds;

        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            in_data  = enc(msg[i]);
            in_last  = give_last && (i == n - 1);
            if (we_at3 && i == 3) begin
                cls_we = 1'b1; cls_sel = 1'b0; cls_addr = 3'd0; cls_wdata = B'(-5);
            end
            while (!in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("in_ready_wait", 64'(w < 20), 64'(1));
            @(posedge clk); #1;
            cls_we = 1'b0;
            if (i == 0) first_acc = cyc;
            if (i == n - 1) begin
                end_acc = cyc;
                e.due   = cyc + 4;
                sb.push_back(e);
            end
        end
        if (!hold_valid) in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cls_we = 1'b0; cls_sel = 1'b0; cls_addr = '0; cls_wdata = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result",    64'(result), 64'(0));
        check("rst_len_err",   64'(len_err), 64'(0));
        check("rst_dot_ham",   64'($signed(dot_ham)), 64'(0));
        check("rst_dot_spam",  64'($signed(dot_spam)), 64'(0));
        check("rst_in_ready",  64'(in_ready), 64'(1));

        // ham all +1, spam all -1
        for (int i = 0; i < DIM; i++) begin ham_m[i] = 1; spam_m[i] = -1; end
        load_mem(1'b0); load_mem(1'b1);
        for (int i = 0; i < DIM; i++) msg[i] = 1;
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();
        for (int i = 0; i < DIM; i++) msg[i] = -1;
        run_frame(8, 1'b1, 1'b0, 4, 1'b0);       // with a mid-frame stall
        wait_idle();

        // full length without in_last
        for (int i = 0; i < DIM; i++) msg[i] = (i % 3 == 0) ? -1 : 1;
        run_frame(8, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();

        // short frame, then a back-to-back frame with in_valid held high
        for (int i = 0; i < DIM; i++) msg[i] = (i == 2) ? -1 : 1;
        run_frame(5, 1'b1, 1'b1, -1, 1'b0);
        begin
            int prev_end;
            prev_end = end_acc;
            for (int i = 0; i < DIM; i++) msg[i] = 1;
            run_frame(8, 1'b1, 1'b0, -1, 1'b0);
            check("back_to_back_accept", 64'(first_acc), 64'(prev_end + 5));
        end
        wait_idle();

        // tie: dh = ds = 2, sh = ss = 4
        for (int i = 0; i < DIM; i++) begin
            ham_m[i]  = (i == 0) ? 2 : 0;
            spam_m[i] = (i < 4) ? 1 : 0;
            msg[i]    = (i < 2) ? 1 : 0;
        end
        load_mem(1'b0); load_mem(1'b1);
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();

        // spam norm zero
        for (int i = 0; i < DIM; i++) begin ham_m[i] = 1; spam_m[i] = 0; msg[i] = 1; end
        load_mem(1'b0); load_mem(1'b1);
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();
        for (int i = 0; i < DIM; i++) ham_m[i] = -1;
        load_mem(1'b0);
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();

        // reset mid-frame aborts with no output
        for (int i = 0; i < DIM; i++) begin ham_m[i] = i - 3; spam_m[i] = 2 - i; end
        load_mem(1'b0); load_mem(1'b1);
        for (int i = 0; i < DIM; i++) msg[i] = (i % 2 == 0) ? 1 : -1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = enc(msg[i]); in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_dot_ham",  64'($signed(dot_ham)), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        repeat (8) begin @(posedge clk); #1; end
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();

        // cls_we during ACCUM is ignored; the re-run proves RAM unchanged
        run_frame(8, 1'b1, 1'b0, -1, 1'b1);
        wait_idle();
        run_frame(8, 1'b1, 1'b0, -1, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
